// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - lane extract/extend, sub-word merge and misalignment detect
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] rdata,
  output logic [31:0] merged,
  output logic        misaligned
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign byte_val = word[{lane, 3'b000} +: 8];
  assign half_val = word[{lane[1], 4'b0000} +: 16];

  // Size 2'b11 falls into the default arm and behaves as a word access.
  always_comb begin
    rdata      = word;
    merged     = wdata;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        rdata  = {{24{sign & byte_val[7]}}, byte_val};
        merged = word;
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        rdata      = {{16{sign & half_val[15]}}, half_val};
        merged     = word;
        merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        misaligned = lane[0];
      end
      default: begin
        misaligned = (lane != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage: FSM, request/merge/response registers
module load_store_unit #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-3:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);
  import lsu_pkg::*;

  if (DATA_WIDTH != 32) begin : g_width_check
    $error("load_store_unit: DATA_WIDTH must be 32");
  end

  state_t                state_q, state_d;
  logic                  write_q, write_d;
  logic [1:0]            size_q, size_d;
  logic                  signed_q, signed_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] merge_q, merge_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  error_q, error_d;

  logic [DATA_WIDTH-1:0] align_word, align_rdata, align_merged;
  logic                  align_misaligned;
  logic                  write_cycle;

  // In MERGE the captured word is the base; otherwise the live memory word is.
  assign align_word = (state_q == MERGE) ? merge_q : mem_data_out;

  lsu_align u_align (
    .word       (align_word),
    .wdata      (wdata_q),
    .lane       (addr_q[1:0]),
    .size       (size_q),
    .sign       (signed_q),
    .rdata      (align_rdata),
    .merged     (align_merged),
    .misaligned (align_misaligned)
  );

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    signed_d    = signed_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    merge_d     = merge_q;
    rdata_d     = rdata_q;
    error_d     = error_q;
    write_cycle = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (align_misaligned) begin
          rdata_d = '0;
          error_d = 1'b1;
          state_d = RESP;
        end else if (!write_q) begin
          rdata_d = align_rdata;
          error_d = 1'b0;
          state_d = RESP;
        end else if (size_q == SZ_BYTE || size_q == SZ_HALF) begin
          merge_d = mem_data_out;
          state_d = MERGE;
        end else begin
          write_cycle = 1'b1;
          rdata_d     = '0;
          error_d     = 1'b0;
          state_d     = RESP;
        end
      end
      MERGE: begin
        write_cycle = 1'b1;
        rdata_d     = '0;
        error_d     = 1'b0;
        state_d     = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
    end
  end

  // Gating with reset keeps an aborted MERGE from landing a write on the reset edge.
  assign mem_write_enable = write_cycle & ~reset;
  assign mem_address      = addr_q[ADDR_WIDTH-1:2];
  assign mem_data_in      = align_merged;
  assign req_ready        = (state_q == IDLE);
  assign resp_valid       = (state_q == RESP);
  assign resp_rdata       = rdata_q;
  assign resp_error       = error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench with a byte-addressed reference memory
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic        mem_write_enable;
  logic [7:0]  mem_address;
  logic [31:0] mem_data_in, mem_data_out;

  logic [31:0] mem [0:255];
  logic        mem_clear;
  logic [7:0]  ref_bytes [0:1023];
  int          total = 0;
  int          bad = 0;
  int          we_count = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_write_enable(mem_write_enable), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  assign mem_data_out = mem[mem_address];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (mem_write_enable) begin
      mem[mem_address] <= mem_data_in;
    end
  end

  always @(negedge clk) if (mem_write_enable) we_count++;

  // Reference: little-endian byte array, natural-alignment rule, plain shifts for extension.
  task automatic model(input logic w, input logic [1:0] sz, input logic sg, input logic [9:0] a,
                       input logic [31:0] wd, output logic [31:0] r, output logic e);
    int n;
    logic [31:0] v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    r = 32'h0;
    e = ((int'(a) % n) != 0);
    if (e) return;
    if (w) begin
      for (int i = 0; i < n; i++) ref_bytes[int'(a) + i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[int'(a) + i]) << (8 * i));
      if (sg && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      r = v;
    end
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg, input logic [9:0] a,
                        input logic [31:0] wd, output logic [31:0] got_r, output logic got_e);
    logic [31:0] er;
    logic        ee;
    int          cyc, el;
    logic        found;
    model(w, sz, sg, a, wd, er, ee);
    el = (w && !ee && sz < 2'd2) ? 3 : 2;
    @(negedge clk);
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL ready_at_issue: got %b want 1", req_ready); end
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc = 0; found = 1'b0;
    while (cyc < 8 && !found) begin
      @(negedge clk);
      cyc++;
      if (resp_valid === 1'b1) found = 1'b1;
    end
    total++;
    if (!found || cyc != el) begin
      bad++; $display("FAIL latency addr=%h: got %0d (found=%b) want %0d", a, cyc, found, el);
    end
    total++;
    if (resp_rdata !== er || resp_error !== ee) begin
      bad++; $display("FAIL resp addr=%h: got %h/%b want %h/%b", a, resp_rdata, resp_error, er, ee);
    end
    got_r = resp_rdata; got_e = resp_error;
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0) begin bad++; $display("FAIL resp_pulse: got %b want 0", resp_valid); end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_clear = 1'b1; req_valid = 1'b0;
    req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 1024; i++) ref_bytes[i] = 8'h0;
    repeat (3) @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_error !== 1'b0 ||
        mem_address !== 8'h0 || mem_write_enable !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: rdy=%b vld=%b rd=%h err=%b ma=%h we=%b want 1 0 0 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_error, mem_address, mem_write_enable);
    end
    reset = 1'b0; mem_clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] r;
    logic        e;
    int          we0;
    do_req(1, 2'd2, 0, 10'h010, 32'hDEADBEEF, r, e);
    do_req(0, 2'd2, 0, 10'h010, 32'h0, r, e);
    total++; if (r !== 32'hDEADBEEF) begin bad++; $display("FAIL word_load: got %h want deadbeef", r); end
    do_req(1, 2'd0, 0, 10'h012, 32'h00000055, r, e);
    do_req(0, 2'd2, 0, 10'h010, 32'h0, r, e);
    total++; if (r !== 32'hDE55BEEF) begin bad++; $display("FAIL byte_merge: got %h want de55beef", r); end
    do_req(0, 2'd0, 1, 10'h013, 32'h0, r, e);
    total++; if (r !== 32'hFFFFFFDE) begin bad++; $display("FAIL byte_signed: got %h want ffffffde", r); end
    do_req(0, 2'd0, 0, 10'h013, 32'h0, r, e);
    total++; if (r !== 32'h000000DE) begin bad++; $display("FAIL byte_unsigned: got %h want 000000de", r); end
    do_req(0, 2'd1, 1, 10'h010, 32'h0, r, e);
    total++; if (r !== 32'hFFFFBEEF) begin bad++; $display("FAIL half_signed: got %h want ffffbeef", r); end
    we0 = we_count;
    do_req(1, 2'd1, 0, 10'h011, 32'h00001234, r, e);
    total++;
    if (e !== 1'b1 || r !== 32'h0) begin bad++; $display("FAIL misaligned: got %h/%b want 0/1", r, e); end
    total++; if (we_count != we0) begin bad++; $display("FAIL misaligned_we: got %0d writes want 0", we_count - we0); end
    do_req(0, 2'd2, 0, 10'h010, 32'h0, r, e);
    total++; if (r !== 32'hDE55BEEF) begin bad++; $display("FAIL after_misaligned: got %h want de55beef", r); end
  endtask

  task automatic test_reset_mid_merge();
    logic [31:0] r;
    logic        e;
    do_req(1, 2'd2, 0, 10'h014, 32'h11223344, r, e);
    @(negedge clk);
    req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 10'h014; req_wdata = 32'hAA;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (mem_write_enable !== 1'b1) begin bad++; $display("FAIL merge_we: got %b want 1", mem_write_enable); end
    reset = 1'b1;
    #1;
    total++;
    if (mem_write_enable !== 1'b0) begin bad++; $display("FAIL reset_gate_we: got %b want 0", mem_write_enable); end
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      bad++; $display("FAIL after_reset: ready=%b valid=%b want 1 0", req_ready, resp_valid);
    end
    total++;
    if (mem[5] !== 32'h11223344) begin bad++; $display("FAIL reset_mem: got %h want 11223344", mem[5]); end
    repeat (3) begin
      @(negedge clk);
      total++;
      if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_no_resp: got %b want 0", resp_valid); end
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic        e;
    logic [9:0]  a;
    for (int k = 0; k < 40; k++) begin
      a = ($urandom_range(0, 3) == 0) ? 10'(1020 + $urandom_range(0, 3)) : 10'($urandom_range(0, 63));
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom, r, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_r [$];
    logic        exp_e [$];
    logic [31:0] er;
    logic        ee;
    logic        prev_ready, prev_valid;
    int          issued, got, cycles;
    issued = 0; got = 0; cycles = 0; prev_ready = 1'b0; prev_valid = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    while ((issued < 16 || exp_r.size() > 0) && cycles < 200) begin
      if (resp_valid === 1'b1) begin
        total++;
        if (prev_valid) begin bad++; $display("FAIL b2b_consecutive_valid at cycle %0d", cycles); end
        if (exp_r.size() == 0) begin
          bad++; $display("FAIL b2b_extra_resp: got %h want none", resp_rdata);
        end else begin
          er = exp_r.pop_front(); ee = exp_e.pop_front(); got++;
          total++;
          if (resp_rdata !== er || resp_error !== ee) begin
            bad++; $display("FAIL b2b_resp %0d: got %h/%b want %h/%b", got, resp_rdata, resp_error, er, ee);
          end
        end
      end
      if (req_ready === 1'b1) begin
        total++;
        if (prev_ready) begin bad++; $display("FAIL b2b_ready_width: ready high two cycles"); end
        if (issued < 16) begin
          req_write  = 1'($urandom_range(0, 1));
          req_size   = 2'($urandom_range(0, 3));
          req_signed = 1'($urandom_range(0, 1));
          req_addr   = 10'($urandom_range(0, 63));
          req_wdata  = $urandom;
          model(req_write, req_size, req_signed, req_addr, req_wdata, er, ee);
          exp_r.push_back(er); exp_e.push_back(ee);
          issued++;
        end else begin
          req_valid = 1'b0;
        end
      end
      prev_ready = req_ready;
      prev_valid = resp_valid;
      @(negedge clk);
      cycles++;
    end
    req_valid = 1'b0;
    total++;
    if (issued != 16 || exp_r.size() != 0) begin
      bad++; $display("FAIL b2b_timeout: issued %0d pending %0d want 16 0", issued, exp_r.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_memory_image();
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      w = {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]};
      total++;
      if (mem[i] !== w) begin bad++; $display("FAIL mem_image word %0d: got %h want %h", i, mem[i], w); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_merge();
    test_random();
    test_back_to_back();
    test_memory_image();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
